// File: rtl/phy_loop_emulator.sv
// TBI/8b10b-level PHY loopback channel model: circular delay line with programmable
// latency, link-down emulation, idle fill after (re)sync and deterministic error injection.
module phy_loop_emulator #(
    parameter int g_data_width = 8,
    parameter int g_max_delay  = 64,
    parameter int g_bitslide   = 0
) (
    input  logic                            clk_ref_i,
    input  logic                            rst_n_i,
    input  logic [g_data_width-1:0]         tx_data_i,
    input  logic [g_data_width/8-1:0]       tx_k_i,
    output logic [g_data_width-1:0]         rx_data_o,
    output logic [g_data_width/8-1:0]       rx_k_o,
    output logic                            rx_enc_err_o,
    output logic [3:0]                      rx_bitslide_o,
    input  logic                            loopen_i,
    input  logic                            link_down_i,
    input  logic [$clog2(g_max_delay)-1:0]  delay_i,
    input  logic [15:0]                     err_period_i,
    input  logic                            err_mode_i,
    input  logic                            err_clr_i,
    output logic [15:0]                     err_count_o,
    output logic [1:0]                      state_o
);

    localparam int c_lanes = g_data_width / 8;
    localparam int c_aw    = $clog2(g_max_delay);
    localparam int c_bw    = $clog2(g_data_width);
    localparam int c_ww    = g_data_width + c_lanes;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [c_aw-1:0]         wr_ptr, rd_addr, delay_q, fill_cnt;
    logic [c_ww-1:0]         mem [g_max_delay];
    logic [c_ww-1:0]         rd_word;
    logic [15:0]             err_period_q, inj_cnt, inj_cnt_eff, inj_cnt_n;
    logic [c_bw-1:0]         bit_idx;
    logic                    link_ok, delay_chg, fill_load, fill_odd, fill_sel, inject;
    logic [g_data_width-1:0] idle_data, flip_mask, rx_data_n;
    logic [c_lanes-1:0]      idle_k, rx_k_n;
    logic                    rx_enc_err_n;

    assign rx_bitslide_o = 4'(g_bitslide);
    assign state_o       = state;
    assign link_ok       = loopen_i && !link_down_i;
    assign delay_chg     = (delay_i != delay_q);

    // NOTE: the delay RAM is deliberately not reset; FILL masks its stale contents.
    always_ff @(posedge clk_ref_i) begin
        mem[wr_ptr] <= {tx_k_i, tx_data_i};
    end

    // The zero-delay word is being written this very cycle, so it bypasses the RAM.
    assign rd_addr = wr_ptr - delay_i;
    assign rd_word = (delay_i == '0) ? {tx_k_i, tx_data_i} : mem[rd_addr];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        fill_load = 1'b0;
        if (!link_ok) begin
            state_n = ST_DOWN;
        end else begin
            case (state)
                ST_DOWN: begin
                    state_n   = ST_FILL;
                    fill_load = 1'b1;
                end
                ST_FILL: begin
                    if (delay_chg) begin
                        fill_load = 1'b1;
                    end else if (fill_cnt == '0) begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (delay_chg) begin
                        state_n   = ST_FILL;
                        fill_load = 1'b1;
                    end
                end
                default: state_n = ST_DOWN;
            endcase
        end
    end

    // A new period restarts counting with the current word as word 0.
    always_comb begin
        inj_cnt_eff = (err_period_i != err_period_q) ? 16'd0 : inj_cnt;
        inject      = (state_n == ST_RUN) && (err_period_i != 16'd0) &&
                      (inj_cnt_eff == err_period_i - 16'd1);
        if ((state_n != ST_RUN) || (err_period_i == 16'd0) || inject) begin
            inj_cnt_n = 16'd0;
        end else begin
            inj_cnt_n = inj_cnt_eff + 16'd1;
        end
    end

    always_comb begin
        fill_sel = fill_load ? 1'b0 : fill_odd;
        if (g_data_width == 16) begin
            idle_data = g_data_width'(16'hBC50);
            idle_k    = c_lanes'(2'b10);
        end else begin
            idle_data = fill_sel ? g_data_width'(8'h50) : g_data_width'(8'hBC);
            idle_k    = fill_sel ? c_lanes'(1'b0) : c_lanes'(1'b1);
        end

        flip_mask = '0;
        if (inject && !err_mode_i) begin
            flip_mask = g_data_width'(1) << bit_idx;
        end

        rx_data_n    = '0;
        rx_k_n       = '0;
        rx_enc_err_n = 1'b1;
        case (state_n)
            ST_FILL: begin
                rx_data_n    = idle_data;
                rx_k_n       = idle_k;
                rx_enc_err_n = 1'b0;
            end
            ST_RUN: begin
                rx_data_n    = rd_word[g_data_width-1:0] ^ flip_mask;
                rx_k_n       = rd_word[c_ww-1:g_data_width];
                rx_enc_err_n = inject && err_mode_i;
            end
            default: ;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments only.
    always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_DOWN;
            wr_ptr       <= '0;
            delay_q      <= '0;
            fill_cnt     <= '0;
            fill_odd     <= 1'b0;
            err_period_q <= 16'd0;
            inj_cnt      <= 16'd0;
            bit_idx      <= '0;
            err_count_o  <= 16'd0;
            rx_data_o    <= '0;
            rx_k_o       <= '0;
            rx_enc_err_o <= 1'b1;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr + c_aw'(1);
            delay_q      <= delay_i;
            err_period_q <= err_period_i;
            inj_cnt      <= inj_cnt_n;
            fill_odd     <= (state_n == ST_FILL) ? ~fill_sel : 1'b0;
            rx_data_o    <= rx_data_n;
            rx_k_o       <= rx_k_n;
            rx_enc_err_o <= rx_enc_err_n;

            if (fill_load) begin
                fill_cnt <= delay_i;
            end else if ((state == ST_FILL) && (fill_cnt != '0)) begin
                fill_cnt <= fill_cnt - c_aw'(1);
            end

            if (inject && !err_mode_i) begin
                bit_idx <= (bit_idx == c_bw'(g_data_width - 1)) ? '0 : bit_idx + c_bw'(1);
            end

            // A clear beats a coincident injection.
            if (err_clr_i) begin
                err_count_o <= 16'd0;
            end else if (inject && (err_count_o != 16'hFFFF)) begin
                err_count_o <= err_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_phy_loop_emulator.sv
// Bench for phy_loop_emulator: an 8-bit and a 16-bit channel driven by shared controls,
// a control/state vector table plus directed latency, error-injection and saturation sequences.
module tb_phy_loop_emulator;

    localparam logic [1:0] S_DOWN = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    typedef struct {
        logic       loopen;
        logic       link_down;
        logic [5:0] delay;
        logic [1:0] exp_state;
        logic       exp_err;
        int         fill_ph;   // -1: width-8 idle phase not checked
    } vec_t;

    logic        clk_ref = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] tx_data16 = '0;
    logic [1:0]  tx_k16    = '0;
    logic [7:0]  tx_data8  = '0;
    logic [0:0]  tx_k8     = '0;
    logic        loopen    = 1'b0;
    logic        link_down = 1'b0;
    logic [5:0]  delay     = '0;
    logic [15:0] err_period = '0;
    logic        err_mode  = 1'b0;
    logic        err_clr   = 1'b0;

    logic [15:0] rx_data16, err_count16;
    logic [1:0]  rx_k16, state16;
    logic        enc16;
    logic [3:0]  slide16;
    logic [7:0]  rx_data8;
    logic [0:0]  rx_k8;
    logic        enc8;
    logic [3:0]  slide8;
    logic [15:0] err_count8;
    logic [1:0]  state8;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [15:0] hist_d [128];
    logic [1:0]  hist_k [128];
    vec_t        tbl [27];

    always #5 clk_ref = ~clk_ref;

    phy_loop_emulator #(.g_data_width(16), .g_max_delay(64), .g_bitslide(5)) u_dut16 (
        .clk_ref_i    (clk_ref),
        .rst_n_i      (rst_n),
        .tx_data_i    (tx_data16),
        .tx_k_i       (tx_k16),
        .rx_data_o    (rx_data16),
        .rx_k_o       (rx_k16),
        .rx_enc_err_o (enc16),
        .rx_bitslide_o(slide16),
        .loopen_i     (loopen),
        .link_down_i  (link_down),
        .delay_i      (delay),
        .err_period_i (err_period),
        .err_mode_i   (err_mode),
        .err_clr_i    (err_clr),
        .err_count_o  (err_count16),
        .state_o      (state16)
    );

    phy_loop_emulator #(.g_data_width(8), .g_max_delay(64), .g_bitslide(0)) u_dut8 (
        .clk_ref_i    (clk_ref),
        .rst_n_i      (rst_n),
        .tx_data_i    (tx_data8),
        .tx_k_i       (tx_k8),
        .rx_data_o    (rx_data8),
        .rx_k_o       (rx_k8),
        .rx_enc_err_o (enc8),
        .rx_bitslide_o(slide8),
        .loopen_i     (loopen),
        .link_down_i  (link_down),
        .delay_i      (delay),
        .err_period_i (err_period),
        .err_mode_i   (err_mode),
        .err_clr_i    (err_clr),
        .err_count_o  (err_count8),
        .state_o      (state8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge and present the next ramp word.
    task automatic cycle();
        @(negedge clk_ref);
        cyc++;
        tx_data16 = cyc[15:0];
        tx_k16    = cyc[3:2];
        tx_data8  = cyc[7:0];
        tx_k8     = 1'b0;
        hist_d[cyc & 127] = tx_data16;
        hist_k[cyc & 127] = tx_k16;
    endtask

    function automatic logic [15:0] past_d(input int lag);
        return hist_d[(cyc - lag) & 127];
    endfunction

    function automatic logic [1:0] past_k(input int lag);
        return hist_k[(cyc - lag) & 127];
    endfunction

    task automatic expect_fill16(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            check("fill_state", state16, S_FILL);
            check("fill_data", rx_data16, 16'hBC50);
            check("fill_k", rx_k16, 2'b10);
            check("fill_err", enc16, 1'b0);
        end
    endtask

    task automatic expect_run16(input int n, input int lag);
        for (int i = 0; i < n; i++) begin
            cycle();
            check("run_state", state16, S_RUN);
            check("run_data", rx_data16, past_d(lag));
            check("run_k", rx_k16, past_k(lag));
            check("run_err", enc16, 1'b0);
        end
    endtask

    initial begin
        // loopen, link_down, delay, expected state, expected enc_err, width-8 idle phase
        tbl[0]  = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 1};
        tbl[4]  = '{1'b1, 1'b0, 6'd3, S_RUN,  1'b0, -1};
        tbl[5]  = '{1'b1, 1'b0, 6'd3, S_RUN,  1'b0, -1};
        tbl[6]  = '{1'b1, 1'b1, 6'd3, S_DOWN, 1'b1, -1};
        tbl[7]  = '{1'b1, 1'b1, 6'd3, S_DOWN, 1'b1, -1};
        tbl[8]  = '{1'b1, 1'b1, 6'd3, S_DOWN, 1'b1, -1};
        tbl[9]  = '{1'b1, 1'b1, 6'd3, S_DOWN, 1'b1, -1};
        tbl[10] = '{1'b1, 1'b1, 6'd3, S_DOWN, 1'b1, -1};
        tbl[11] = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 0};
        tbl[12] = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 1};
        tbl[13] = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 0};
        tbl[14] = '{1'b1, 1'b0, 6'd3, S_FILL, 1'b0, 1};
        tbl[15] = '{1'b1, 1'b0, 6'd3, S_RUN,  1'b0, -1};
        tbl[16] = '{1'b1, 1'b0, 6'd2, S_FILL, 1'b0, 0};
        tbl[17] = '{1'b1, 1'b0, 6'd5, S_FILL, 1'b0, -1};
        tbl[18] = '{1'b1, 1'b0, 6'd5, S_FILL, 1'b0, -1};
        tbl[19] = '{1'b1, 1'b0, 6'd5, S_FILL, 1'b0, -1};
        tbl[20] = '{1'b1, 1'b0, 6'd5, S_FILL, 1'b0, -1};
        tbl[21] = '{1'b1, 1'b0, 6'd5, S_FILL, 1'b0, -1};
        tbl[22] = '{1'b1, 1'b0, 6'd5, S_FILL, 1'b0, -1};
        tbl[23] = '{1'b1, 1'b0, 6'd5, S_RUN,  1'b0, -1};
        tbl[24] = '{1'b1, 1'b1, 6'd7, S_DOWN, 1'b1, -1};
        tbl[25] = '{1'b0, 1'b0, 6'd7, S_DOWN, 1'b1, -1};
        tbl[26] = '{1'b1, 1'b0, 6'd7, S_FILL, 1'b0, 0};

        // Reset state.
        repeat (3) cycle();
        check("rst_state16", state16, S_DOWN);
        check("rst_data16", rx_data16, 16'h0000);
        check("rst_k16", rx_k16, 2'b00);
        check("rst_err16", enc16, 1'b1);
        check("rst_cnt16", err_count16, 16'h0000);
        check("rst_slide16", slide16, 4'd5);
        check("rst_slide8", slide8, 4'd0);
        check("rst_state8", state8, S_DOWN);
        check("rst_err8", enc8, 1'b1);

        // Zero delay: one idle word, then rx follows tx one cycle later.
        rst_n  = 1'b1;
        loopen = 1'b1;
        delay  = 6'd0;
        cycle();
        check("d0_state", state16, S_FILL);
        check("d0_fill8", rx_data8, 8'hBC);
        check("d0_fillk8", rx_k8, 1'b1);
        check("d0_fill16", rx_data16, 16'hBC50);
        check("d0_err8", enc8, 1'b0);
        for (int i = 0; i < 259; i++) begin
            cycle();
            check("d0_run_state8", state8, S_RUN);
            check("d0_run_data8", rx_data8, past_d(1) & 16'h00FF);
            check("d0_run_k8", rx_k8, 1'b0);
            check("d0_run_data16", rx_data16, past_d(1));
        end

        // Maximum delay: 64 idle words, then 64-cycle latency across the RAM wrap.
        delay = 6'd63;
        expect_fill16(64);
        expect_run16(150, 64);

        // Delay 10: 11 idle words, then 11-cycle latency.
        delay = 6'd10;
        expect_fill16(11);
        expect_run16(100, 11);
        check("cnt_idle", err_count16, 16'h0000);

        // Control table: delay changes, link-down pulse, FILL restart, priority.
        for (int i = 0; i < 27; i++) begin
            loopen    = tbl[i].loopen;
            link_down = tbl[i].link_down;
            delay     = tbl[i].delay;
            cycle();
            check($sformatf("tbl%0d_state", i), state16, tbl[i].exp_state);
            check($sformatf("tbl%0d_err", i), enc16, tbl[i].exp_err);
            case (tbl[i].exp_state)
                S_DOWN: begin
                    check($sformatf("tbl%0d_data", i), rx_data16, 16'h0000);
                    check($sformatf("tbl%0d_k", i), rx_k16, 2'b00);
                end
                S_FILL: begin
                    check($sformatf("tbl%0d_data", i), rx_data16, 16'hBC50);
                    check($sformatf("tbl%0d_k", i), rx_k16, 2'b10);
                    if (tbl[i].fill_ph >= 0) begin
                        check($sformatf("tbl%0d_data8", i), rx_data8,
                              (tbl[i].fill_ph == 1) ? 8'h50 : 8'hBC);
                        check($sformatf("tbl%0d_k8", i), rx_k8, (tbl[i].fill_ph == 1) ? 1'b0 : 1'b1);
                    end
                end
                default: begin
                    check($sformatf("tbl%0d_data", i), rx_data16, past_d(1 + int'(tbl[i].delay)));
                end
            endcase
        end

        // Error injection, mode 0: words 99, 199, ... get bit 0, 1, 2, ... flipped.
        err_period = 16'd100;
        err_mode   = 1'b0;
        expect_fill16(7);
        for (int k = 0; k < 1000; k++) begin
            cycle();
            check("inj0_state", state16, S_RUN);
            check("inj0_data", rx_data16,
                  past_d(8) ^ (((k % 100) == 99) ? (16'd1 << ((k / 100) % 16)) : 16'd0));
            check("inj0_k", rx_k16, past_k(8));
            check("inj0_err", enc16, 1'b0);
        end
        check("inj0_count", err_count16, 16'd10);

        // Mode 1: same positions flag enc_err with data intact.
        err_mode = 1'b1;
        for (int k = 1000; k < 1300; k++) begin
            cycle();
            check("inj1_data", rx_data16, past_d(8));
            check("inj1_err", enc16, ((k % 100) == 99) ? 1'b1 : 1'b0);
        end
        check("inj1_count", err_count16, 16'd13);

        // Period 1: every word injected, counter saturates.
        err_period = 16'd1;
        for (int n = 1; n <= 65600; n++) begin
            cycle();
            if (n == 100) begin
                check("sat_cnt100", err_count16, 16'd113);
                check("sat_err100", enc16, 1'b1);
            end
            if (n == 65521) check("sat_cnt_fffe", err_count16, 16'hFFFE);
            if (n == 65522) check("sat_cnt_ffff", err_count16, 16'hFFFF);
            if (n == 65600) check("sat_cnt_hold", err_count16, 16'hFFFF);
        end

        // Clear coinciding with an injection wins.
        err_clr = 1'b1;
        cycle();
        check("clr_cnt", err_count16, 16'h0000);
        err_clr = 1'b0;
        cycle();
        check("clr_cnt_next", err_count16, 16'h0001);

        // Asynchronous reset mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        check("arst_state", state16, S_DOWN);
        check("arst_data", rx_data16, 16'h0000);
        check("arst_k", rx_k16, 2'b00);
        check("arst_err", enc16, 1'b1);
        check("arst_cnt", err_count16, 16'h0000);
        check("arst_data8", rx_data8, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_loop_emulator.md
Name: phy_loop_emulator

Overview:
- Synthesizable TBI/8b10b-level PHY loopback channel model. It replaces the plain wire loopback (rx = tx) used in the wr_core simulation top.
- Sits between the wr_core PHY tx outputs and PHY rx inputs, on the PHY reference clock.
- Adds parametrised data width, programmable channel latency, link-down emulation and deterministic error injection with an error counter. PTP link bring-up, loss-of-sync and latency-asymmetry paths can then be exercised without a real GTP.

Parameters:
- g_data_width, 8, symbol path width in bits; 8 or 16 only (byte lanes = g_data_width/8).
- g_max_delay, 64, delay line depth in words; power of 2, range 2..1024.
- g_bitslide, 0, constant value driven on rx_bitslide_o (0..15).

Ports:
- clk_ref_i  in  1  PHY reference clock; all logic is on its rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- tx_data_i  in  g_data_width  symbols from the core's phy_tx_data_o.
- tx_k_i  in  g_data_width/8  K-flags, one per byte lane.
- rx_data_o  out  g_data_width  symbols to the core's phy_rx_data_i.
- rx_k_o  out  g_data_width/8  K-flags to the core.
- rx_enc_err_o  out  1  code-error / loss-of-signal flag.
- rx_bitslide_o  out  4  constant g_bitslide.
- loopen_i  in  1  1 = channel enabled; 0 = behaves as link down.
- link_down_i  in  1  1 = force loss of signal.
- delay_i  in  log2(g_max_delay)  extra latency in words.
- err_period_i  in  16  inject one error every N RUN words; 0 = injection off.
- err_mode_i  in  1  0 = flip one data bit silently; 1 = pass data unmodified, assert rx_enc_err_o.
- err_clr_i  in  1  synchronous clear of err_count_o.
- err_count_o  out  16  injected-error count, saturating.
- state_o  out  2  0 = DOWN, 1 = FILL, 2 = RUN.

Behaviour:
- Reset values:
  - state DOWN; rx_data_o = 0; rx_k_o = 0; rx_enc_err_o = 1.
  - err_count_o = 0; write pointer = 0; injection counter = 0; bit index = 0.
  - rx_bitslide_o = g_bitslide at all times.
- Delay line:
  - Circular RAM of g_max_delay words (data + k).
  - Write pointer increments every cycle in every state, wrapping modulo g_max_delay.
  - Read address = wr_ptr - delay_i, modulo g_max_delay.
  - Outputs are registered. In RUN, the word presented at tx in cycle t appears at rx in cycle t + delay_i + 1.
- State DOWN:
  - rx_data_o = 0, rx_k_o = 0, rx_enc_err_o = 1.
  - Exit to FILL when loopen_i = 1 and link_down_i = 0.
- State FILL:
  - Outputs idle ordered sets, rx_enc_err_o = 0.
  - Width 16: data 0xBC50, k = 2'b10, every cycle.
  - Width 8: alternates 0xBC/k = 1 and 0x50/k = 0, starting with 0xBC on the first FILL cycle.
  - A fill counter loads delay_i on entry. FILL lasts exactly delay_i + 1 cycles, then goes to RUN.
- State RUN:
  - Passes delayed words.
  - Any change of delay_i (compared with a registered copy) forces FILL in the next cycle, with the counter reloaded to the new value.
- Priority:
  - link_down_i = 1 or loopen_i = 0 forces DOWN from any state in the next cycle. This overrides a delay change.
  - A delay change in FILL restarts FILL.
- Error injection:
  - Active only in RUN with err_period_i != 0.
  - The injection counter counts RUN words from 0. On reaching err_period_i - 1, the current output word is corrupted and the counter returns to 0.
  - Mode 0: XOR bit (bit_idx) of rx_data_o, where bit_idx cycles 0, 1, ... g_data_width-1, 0. rx_k_o is unchanged.
  - Mode 1: data unmodified; rx_enc_err_o = 1 for that word only.
  - The injection counter resets to 0 on leaving RUN and when err_period_i changes.
- Error counter:
  - err_count_o increments by 1 per injected word and saturates at 0xFFFF.
  - err_clr_i clears it. If a clear and an injection happen in the same cycle, clear wins (result 0).
- Asynchronous reset mid-operation returns all state to reset values immediately. RAM contents are don't-care, because FILL masks stale data.

Test Plan:
1. Reset, loopen = 1, delay = 0, ramp 0x00..0xFF (k = 0) -> exactly 1 FILL cycle (0xBC, k = 1), then rx = tx delayed 1 cycle; state_o 0 -> 1 -> 2.
2. Width 16, delay = 10, ramp -> 11 idle words 0xBC50/k = 10, then rx_data(t) = tx_data(t-11); no enc_err.
3. In RUN, change delay 10 -> 3 -> 4 FILL cycles, then rx = tx delayed 4; delay 63 (max) -> 64-cycle latency with correct wrap-around.
4. err_period = 100, mode 0, 1000 RUN words -> exactly words 99, 199, ... corrupted, each with a single flipped bit at indices 0, 1, 2, ...; err_count_o = 10. Mode 1 -> same positions show rx_enc_err_o = 1 with data intact.
5. link_down pulse of 5 cycles in RUN -> next cycle rx_data = 0, enc_err = 1 for 5 cycles, then FILL of delay_i + 1 cycles, then RUN.
6. err_period = 1 for 70000 cycles -> err_count_o saturates at 0xFFFF; err_clr_i coinciding with an injection -> err_count_o = 0.
